// File: rtl/tester_common.sv
// Shared types for the speed tester: Q8.8 rates, Q16.8 credit buckets and
// the per-port scheduler configuration captured at start.
package tester_common;

  typedef logic [15:0] rate_q88_t;
  typedef logic [23:0] bucket_t;
  typedef logic [10:0] frame_len_t;

  typedef struct packed {
    rate_q88_t  rate_inc;
    frame_len_t frame_len;
  } sched_cfg_t;

  typedef enum logic {
    PORT_IDLE   = 1'b0,
    PORT_ACTIVE = 1'b1
  } port_state_t;

  // Frame length in bytes expressed as Q16.8 credit
  function automatic bucket_t len_to_credit(input frame_len_t len);
    return {5'd0, len, 8'd0};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above the last grant,
// wrapping around; the last granted port has lowest priority.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any_valid
);

  int         idx;
  logic [W-1:0] idx_w;

  // Scan offsets 1..N from the last grant and keep the first hit
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 1; k <= N; k++) begin
      idx   = (int'(last) + k) % N;
      idx_w = W'(idx);
      if (!any_valid && req[idx_w]) begin
        winner    = idx_w;
        any_valid = 1'b1;
      end else begin
        winner    = winner;
      end
    end
  end

endmodule

// File: rtl/tx_rate_scheduler.sv
// Token-bucket pacing for each test port plus a round-robin grant channel
// feeding the shared frame builder; counts accepted grants per port.
module tx_rate_scheduler
  import tester_common::*;
#(
  parameter int TEST_PORT_NUM = 4,
  parameter int BURST_BYTES   = 4096,
  parameter int CNT_W         = 32,
  parameter int PW            = (TEST_PORT_NUM > 1) ? $clog2(TEST_PORT_NUM) : 1
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           rst,
  input  logic [TEST_PORT_NUM-1:0]       start,
  input  logic [TEST_PORT_NUM-1:0]       stop,
  input  logic [TEST_PORT_NUM*16-1:0]    rate_inc,
  input  logic [TEST_PORT_NUM*11-1:0]    frame_len,
  input  logic [TEST_PORT_NUM-1:0]       gen_ready,
  output logic                           grant_valid,
  output logic [PW-1:0]                  grant_port,
  input  logic                           grant_ready,
  output logic [TEST_PORT_NUM-1:0]       port_active,
  output logic [TEST_PORT_NUM*CNT_W-1:0] sent_frames
);

  localparam logic [24:0] BUCKET_MAX = 25'(BURST_BYTES) << 8;

  logic [TEST_PORT_NUM-1:0] eligible_s;
  logic                     any_eligible_s;
  logic [PW-1:0]            winner_s;
  logic                     issue_s;
  logic                     handshake_s;
  logic                     grant_valid_r;
  logic [PW-1:0]            grant_port_r;
  logic [PW-1:0]            last_granted_r;

  rr_arbiter #(
    .N(TEST_PORT_NUM),
    .W(PW)
  ) u_arb (
    .req      (eligible_s),
    .last     (last_granted_r),
    .winner   (winner_s),
    .any_valid(any_eligible_s)
  );

  // A pending grant freezes issuing, so buckets are never debited twice
  assign issue_s     = (!grant_valid_r || grant_ready) && any_eligible_s;
  assign handshake_s = grant_valid_r && grant_ready;

  for (genvar g = 0; g < TEST_PORT_NUM; g++) begin : g_port
    port_state_t        state_r;
    port_state_t        state_s;
    sched_cfg_t         cfg_r;
    bucket_t            bucket_r;
    bucket_t            bucket_s;
    bucket_t            credit_s;
    logic [24:0]        sum_s;
    logic               start_ok_s;
    logic               debit_s;
    logic [CNT_W-1:0]   sent_r;

    // Stop has priority over start; start is ignored while active
    always_comb begin
      state_s = state_r;
      case (state_r)
        PORT_IDLE: begin
          if (start[g] && !stop[g]) state_s = PORT_ACTIVE;
          else                      state_s = PORT_IDLE;
        end
        PORT_ACTIVE: begin
          if (stop[g]) state_s = PORT_IDLE;
          else         state_s = PORT_ACTIVE;
        end
        default: state_s = PORT_IDLE;
      endcase
    end

    assign start_ok_s = (state_r == PORT_IDLE) && start[g] && !stop[g];
    assign credit_s   = len_to_credit(cfg_r.frame_len);
    assign eligible_s[g] = (state_r == PORT_ACTIVE) && (cfg_r.frame_len != 11'd0) &&
                           (bucket_r >= credit_s) && gen_ready[g];
    assign debit_s    = issue_s && (winner_s == PW'(g));

    // Refill, debit on issue, clip at the burst ceiling
    always_comb begin
      sum_s = {1'b0, bucket_r} + {9'd0, cfg_r.rate_inc};
      if (debit_s) sum_s = sum_s - {1'b0, credit_s};
      else         sum_s = sum_s;
      if (sum_s > BUCKET_MAX) bucket_s = BUCKET_MAX[23:0];
      else                    bucket_s = sum_s[23:0];
    end

    // Port state, captured configuration and bucket
    always_ff @(posedge S_AXI_ACLK) begin
      if (rst) begin
        state_r  <= PORT_IDLE;
        cfg_r    <= '0;
        bucket_r <= 24'd0;
      end else begin
        state_r <= state_s;
        if (start_ok_s) begin
          cfg_r.rate_inc  <= rate_inc[g*16 +: 16];
          cfg_r.frame_len <= frame_len[g*11 +: 11];
        end
        if (state_r == PORT_ACTIVE && !stop[g]) bucket_r <= bucket_s;
        else                                    bucket_r <= 24'd0;
      end
    end

    // Accepted-grant counter; counts even after the port went idle
    always_ff @(posedge S_AXI_ACLK) begin
      if (rst) begin
        sent_r <= '0;
      end else if (start_ok_s) begin
        sent_r <= '0;
      end else if (handshake_s && grant_port_r == PW'(g) && sent_r != {CNT_W{1'b1}}) begin
        sent_r <= sent_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    assign port_active[g]                 = (state_r == PORT_ACTIVE);
    assign sent_frames[g*CNT_W +: CNT_W]  = sent_r;
  end

  // Grant register holds valid/port stable until accepted
  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      grant_valid_r  <= 1'b0;
      grant_port_r   <= '0;
      last_granted_r <= PW'(TEST_PORT_NUM - 1);
    end else if (issue_s) begin
      grant_valid_r  <= 1'b1;
      grant_port_r   <= winner_s;
      last_granted_r <= winner_s;
    end else if (grant_ready) begin
      grant_valid_r  <= 1'b0;
    end
  end

  assign grant_valid = grant_valid_r;
  assign grant_port  = grant_port_r;

endmodule

// File: tb/tb_tx_rate_scheduler.sv
// Directed scoreboard bench for tx_rate_scheduler: stimulus queues the
// expected grant ports, an independent monitor checks every handshake.
module tb_tx_rate_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [63:0] rate_inc;
  logic [43:0] frame_len;
  logic [3:0]  gen_ready;
  logic        grant_valid;
  logic [1:0]  grant_port;
  logic        grant_ready;
  logic [3:0]  port_active;
  logic [127:0] sent_frames;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic       hold_prev = 1'b0;
  logic [1:0] hold_port = 2'd0;

  tx_rate_scheduler #(
    .TEST_PORT_NUM(4),
    .BURST_BYTES  (4096),
    .CNT_W        (32)
  ) dut (
    .S_AXI_ACLK (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .rate_inc   (rate_inc),
    .frame_len  (frame_len),
    .gen_ready  (gen_ready),
    .grant_valid(grant_valid),
    .grant_port (grant_port),
    .grant_ready(grant_ready),
    .port_active(port_active),
    .sent_frames(sent_frames)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sent(input int p);
    return longint'(sent_frames[p*32 +: 32]);
  endfunction

  task automatic cfg_port(input int p, input logic [15:0] r, input logic [10:0] l);
    rate_inc[p*16 +: 16]  = r;
    frame_len[p*11 +: 11] = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every handshake pops one expected port; pending grants must hold
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!grant_valid || grant_port != hold_port) begin
          errors++;
          $display("FAIL hold_stable: valid=%0d port=%0d expected valid=1 port=%0d",
                   grant_valid, grant_port, hold_port);
        end
      end
      if (grant_valid && grant_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: port=%0d expected no grant", grant_port);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(grant_port) != e) begin
            errors++;
            $display("FAIL grant_port: got %0d expected %0d", grant_port, e);
          end
        end
      end
      hold_prev = grant_valid && !grant_ready;
      hold_port = grant_port;
    end
  end

  initial begin
    int n;
    int m;
    logic seen;
    longint mx;
    longint mn;
    rst = 1'b1; start = 4'd0; stop = 4'd0; rate_inc = 64'd0; frame_len = 44'd0;
    gen_ready = 4'd0; grant_ready = 1'b0;

    // Reset values
    do_reset();
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_port", grant_port, 0);
    check("rst_port_active", port_active, 0);
    check("rst_sent", sent(0) + sent(1) + sent(2) + sent(3), 0);

    // Single port pacing: 1 byte/cycle, 64-byte frames
    cfg_port(0, 16'h0100, 11'd64);
    gen_ready = 4'hF; grant_ready = 1'b1;
    for (int k = 0; k < 10; k++) exp_q.push_back(0);
    start = 4'b0001; tick(); start = 4'd0;
    check("t1_active", port_active, 1);
    seen = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (grant_valid) seen = 1'b1;
    end
    check("t1_no_early_grant", seen, 0);
    tick();
    check("t1_first_grant_valid", grant_valid, 1);
    check("t1_first_grant_port", grant_port, 0);
    for (int g = 0; g < 3; g++) begin
      n = 0;
      do begin tick(); n++; end while (!grant_valid && n < 200);
      check("t1_grant_gap", n, 64);
    end
    n = 0;
    while (sent(0) != 10 && n < 1000) begin tick(); n++; end
    check("t1_sent10", sent(0), 10);
    stop = 4'b0001; tick(); stop = 4'd0;
    check("t1_stopped", port_active, 0);
    tick(); tick();
    check("t1_queue_empty", exp_q.size(), 0);

    // Four ports, 64 bytes/cycle each: strict rotation
    do_reset();
    for (int p = 0; p < 4; p++) cfg_port(p, 16'h4000, 11'd64);
    for (int k = 0; k < 5; k++) for (int p = 0; p < 4; p++) exp_q.push_back(p);
    start = 4'hF; tick(); start = 4'd0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      mx = sent(0); mn = sent(0);
      for (int p = 1; p < 4; p++) begin
        if (sent(p) > mx) mx = sent(p);
        if (sent(p) < mn) mn = sent(p);
      end
      check("t2_fair", (mx - mn) <= 1, 1);
    end
    stop = 4'hF; tick(); stop = 4'd0;
    tick(); tick();
    for (int p = 0; p < 4; p++) check("t2_sent5", sent(p), 5);
    check("t2_queue_empty", exp_q.size(), 0);

    // Held grant for port 2, then stop while pending
    do_reset();
    grant_ready = 1'b0;
    cfg_port(2, 16'h4000, 11'd64);
    start = 4'b0100; tick(); start = 4'd0;
    tick(); tick();
    check("t3_grant_valid", grant_valid, 1);
    check("t3_grant_port", grant_port, 2);
    for (int k = 0; k < 20; k++) tick();
    check("t3_held_port", grant_port, 2);
    check("t3_no_count", sent(0) + sent(1) + sent(2) + sent(3), 0);
    exp_q.push_back(2);
    grant_ready = 1'b1; tick(); grant_ready = 1'b0;
    check("t3_one_inc", sent(2), 1);
    check("t3_next_pending", grant_valid, 1);
    stop = 4'b0100; tick(); stop = 4'd0;
    check("t5_stopped", port_active[2], 0);
    check("t5_still_pending", grant_valid, 1);
    check("t5_pending_port", grant_port, 2);
    exp_q.push_back(2);
    grant_ready = 1'b1; tick();
    check("t5_sent_after_stop", sent(2), 2);
    seen = grant_valid;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (grant_valid) seen = 1'b1;
    end
    check("t5_no_more_grants", seen, 0);

    // Saturation then burst: 8 bytes/cycle, 256-byte frames
    do_reset();
    gen_ready = 4'b1110; grant_ready = 1'b1;
    cfg_port(0, 16'h0800, 11'd256);
    start = 4'b0001; tick(); start = 4'd0;
    for (int k = 0; k < 600; k++) tick();
    for (int k = 0; k < 17; k++) exp_q.push_back(0);
    gen_ready = 4'hF;
    n = 0;
    tick();
    while (grant_valid && n < 100) begin n++; tick(); end
    check("t4_burst_len", n, 16);
    m = 0;
    do begin tick(); m++; end while (!grant_valid && m < 100);
    check("t4_refill_gap", m, 16);
    stop = 4'b0001; tick(); stop = 4'd0;
    check("t4_sent", sent(0), 17);
    check("t4_queue_empty", exp_q.size(), 0);

    // start+stop together, zero rate, zero length
    cfg_port(0, 16'h4000, 11'd64);
    start = 4'b0001; stop = 4'b0001; tick(); start = 4'd0; stop = 4'd0;
    check("t6_startstop_idle", port_active[0], 0);
    cfg_port(1, 16'h0000, 11'd64);
    cfg_port(2, 16'h4000, 11'd0);
    start = 4'b0110; tick(); start = 4'd0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (grant_valid) seen = 1'b1;
    end
    check("t6_no_grants", seen, 0);
    check("t6_active", port_active, 4'b0110);
    check("t6_sent_kept", sent(0), 17);

    // Reset mid-run with a pending grant
    grant_ready = 1'b0;
    cfg_port(3, 16'h4000, 11'd64);
    start = 4'b1000; tick(); start = 4'd0;
    tick(); tick();
    check("t7_pending_port", grant_port, 3);
    rst = 1'b1; tick();
    check("t7_rst_valid", grant_valid, 0);
    check("t7_rst_port", grant_port, 0);
    check("t7_rst_active", port_active, 0);
    check("t7_rst_sent", sent(0), 0);
    rst = 1'b0;
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
